// File: rtl/leve1_wb_sched.sv
`timescale 1ns/1ps
// leve1_wb_sched: shares the single register-file write port between pipeline WB and
// buffered long-op completions, and keeps the busy scoreboard behind the ID interlock.
module leve1_wb_sched #(
  parameter int XLEN       = 64,
  parameter int NUM_REG    = 32,
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            P_VALID,
  input  logic [4:0]      P_RD,
  input  logic [XLEN-1:0] P_DATA,
  output logic            HOLD,
  input  logic            L_ISSUE,
  input  logic [4:0]      L_ISSUE_RD,
  input  logic            L_DONE_VALID,
  output logic            L_DONE_READY,
  input  logic [4:0]      L_DONE_RD,
  input  logic [XLEN-1:0] L_DONE_DATA,
  input  logic            ID_VALID,
  input  logic [4:0]      ID_RS1,
  input  logic [4:0]      ID_RS2,
  input  logic [4:0]      ID_RD,
  output logic            STALL,
  output logic            RF_WE,
  output logic [4:0]      RF_WA,
  output logic [XLEN-1:0] RF_WD
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  // Completion handshake: a completion is taken on any cycle where
  // L_DONE_VALID & L_DONE_READY; READY depends only on registered fill level,
  // so a pop in the same cycle does not raise READY until the next edge.

  logic [NUM_REG-1:0] r_busy;
  logic [NUM_REG-1:0] w_busy_nxt;

  logic [4:0]         r_fifo_rd   [LQ_DEPTH];
  logic [XLEN-1:0]    r_fifo_data [LQ_DEPTH];
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W-1:0]   r_wptr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;

  logic [STV_W-1:0]   r_starve;
  logic [STV_W-1:0]   w_starve_nxt;

  logic               r_rf_we;
  logic [4:0]         r_rf_wa;
  logic [XLEN-1:0]    r_rf_wd;

  logic               w_preq;
  logic               w_lreq;
  logic               w_full;
  logic               w_starved;
  logic               w_grant_l;
  logic               w_grant_p;
  logic               w_push;
  logic [4:0]         w_head_rd;
  logic [XLEN-1:0]    w_head_data;

  assign w_preq      = P_VALID & (P_RD != 5'd0);
  assign w_lreq      = (r_count != '0);
  assign w_full      = (r_count == CNT_W'(LQ_DEPTH));
  assign w_starved   = (r_starve == STV_W'(STARVE_MAX));
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Buffer head wins only when the pipeline is idle or has starved it long enough.
  assign w_grant_l = w_lreq & (~w_preq | w_starved);
  assign w_grant_p = w_preq & ~w_grant_l;

  // x0 completions are acknowledged but never stored.
  assign w_push = L_DONE_VALID & ~w_full & (L_DONE_RD != 5'd0);

  assign HOLD         = w_preq & w_grant_l;
  assign L_DONE_READY = ~w_full;
  assign STALL        = ID_VALID & (r_busy[ID_RS1] | r_busy[ID_RS2] | r_busy[ID_RD]);

  assign RF_WE = r_rf_we;
  assign RF_WA = r_rf_wa;
  assign RF_WD = r_rf_wd;

  // Set after clear so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_l) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (L_ISSUE && (L_ISSUE_RD != 5'd0)) begin
      w_busy_nxt[L_ISSUE_RD] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_grant_l})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (w_grant_l || !w_lreq) begin
      w_starve_nxt = '0;
    end else if (w_preq) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_busy   <= '0;
      r_count  <= '0;
      r_rptr   <= '0;
      r_wptr   <= '0;
      r_starve <= '0;
    end else begin
      r_busy   <= w_busy_nxt;
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      if (w_grant_l) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        r_fifo_rd[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else if (w_push) begin
      r_fifo_rd[r_wptr]   <= L_DONE_RD;
      r_fifo_data[r_wptr] <= L_DONE_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= '0;
      r_rf_wd <= '0;
    end else begin
      r_rf_we <= w_grant_l | w_grant_p;
      if (w_grant_l) begin
        r_rf_wa <= w_head_rd;
        r_rf_wd <= w_head_data;
      end else if (w_grant_p) begin
        r_rf_wa <= P_RD;
        r_rf_wd <= P_DATA;
      end
    end
  end

  a_x0_never_busy: assert property (@(posedge CLK) disable iff (!RSTn) !r_busy[0]);
  a_fifo_bounded:  assert property (@(posedge CLK) disable iff (!RSTn) r_count <= CNT_W'(LQ_DEPTH));
  a_no_p_waw:      assert property (@(posedge CLK) disable iff (!RSTn) !(w_preq && r_busy[P_RD]));

endmodule

// File: tb/tb_leve1_wb_sched.sv
`timescale 1ns/1ps
// tb_leve1_wb_sched: vector table, directed multi-cycle sequences and a
// queue-based reference model for randomized traffic.
module tb_leve1_wb_sched;

  localparam int XLEN       = 64;
  localparam int LQ_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            P_VALID;
  logic [4:0]      P_RD;
  logic [XLEN-1:0] P_DATA;
  logic            HOLD;
  logic            L_ISSUE;
  logic [4:0]      L_ISSUE_RD;
  logic            L_DONE_VALID;
  logic            L_DONE_READY;
  logic [4:0]      L_DONE_RD;
  logic [XLEN-1:0] L_DONE_DATA;
  logic            ID_VALID;
  logic [4:0]      ID_RS1;
  logic [4:0]      ID_RS2;
  logic [4:0]      ID_RD;
  logic            STALL;
  logic            RF_WE;
  logic [4:0]      RF_WA;
  logic [XLEN-1:0] RF_WD;

  leve1_wb_sched #(
    .XLEN(XLEN), .NUM_REG(32), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .P_VALID(P_VALID), .P_RD(P_RD), .P_DATA(P_DATA), .HOLD(HOLD),
    .L_ISSUE(L_ISSUE), .L_ISSUE_RD(L_ISSUE_RD),
    .L_DONE_VALID(L_DONE_VALID), .L_DONE_READY(L_DONE_READY),
    .L_DONE_RD(L_DONE_RD), .L_DONE_DATA(L_DONE_DATA),
    .ID_VALID(ID_VALID), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RD(ID_RD),
    .STALL(STALL), .RF_WE(RF_WE), .RF_WA(RF_WA), .RF_WD(RF_WD)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0b required %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    P_VALID = 1'b0; P_RD = '0; P_DATA = '0;
    L_ISSUE = 1'b0; L_ISSUE_RD = '0;
    L_DONE_VALID = 1'b0; L_DONE_RD = '0; L_DONE_DATA = '0;
    ID_VALID = 1'b0; ID_RS1 = '0; ID_RS2 = '0; ID_RD = '0;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  typedef struct {
    logic pv; logic [4:0] prd; logic [63:0] pd;
    logic li; logic [4:0] lird;
    logic ldv; logic [4:0] ldrd; logic [63:0] ldd;
    logic idv; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] idrd;
    logic e_stall; logic e_hold; logic e_ready; logic e_we;
    logic [4:0] e_wa; logic [63:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic pv, input logic [4:0] prd, input logic [63:0] pd,
    input logic li, input logic [4:0] lird,
    input logic ldv, input logic [4:0] ldrd, input logic [63:0] ldd,
    input logic idv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] idrd,
    input logic e_stall, input logic e_hold, input logic e_ready, input logic e_we,
    input logic [4:0] e_wa, input logic [63:0] e_wd);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.li = li; v.lird = lird;
    v.ldv = ldv; v.ldrd = ldrd; v.ldd = ldd;
    v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.idrd = idrd;
    v.e_stall = e_stall; v.e_hold = e_hold; v.e_ready = e_ready; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    P_VALID = v.pv; P_RD = v.prd; P_DATA = v.pd;
    L_ISSUE = v.li; L_ISSUE_RD = v.lird;
    L_DONE_VALID = v.ldv; L_DONE_RD = v.ldrd; L_DONE_DATA = v.ldd;
    ID_VALID = v.idv; ID_RS1 = v.rs1; ID_RS2 = v.rs2; ID_RD = v.idrd;
    @(negedge CLK);
    chk1($sformatf("vec%0d_stall", idx), STALL, v.e_stall);
    chk1($sformatf("vec%0d_hold", idx), HOLD, v.e_hold);
    chk1($sformatf("vec%0d_ready", idx), L_DONE_READY, v.e_ready);
    chk1($sformatf("vec%0d_we", idx), RF_WE, v.e_we);
    if (v.e_we) begin
      chk5($sformatf("vec%0d_wa", idx), RF_WA, v.e_wa);
      chk64($sformatf("vec%0d_wd", idx), RF_WD, v.e_wd);
    end
    next_cycle();
  endtask

  // scoreboard / reference model state
  bit             mbusy [32];
  logic [68:0]    mfifo [$];
  int             mstarve;
  logic [68:0]    exp_q [$];
  logic [4:0]     unit_q [$];

  logic [4:0]  prd_s [9];
  logic [4:0]  bp_wa [9];
  logic [63:0] bp_wd [9];
  logic        bp_we [9];
  logic        bp_rdy [9];

  initial begin
    idle_inputs();

    // reset state, sampled while held and after release
    @(negedge CLK);
    chk1("rst_held_we", RF_WE, 1'b0);
    chk1("rst_held_ready", L_DONE_READY, 1'b1);
    do_reset();
    ID_VALID = 1'b1; ID_RS1 = 5'd5; ID_RS2 = 5'd7; ID_RD = 5'd9;
    @(negedge CLK);
    chk1("rst_we", RF_WE, 1'b0);
    chk1("rst_stall", STALL, 1'b0);
    chk1("rst_ready", L_DONE_READY, 1'b1);
    chk1("rst_hold", HOLD, 1'b0);
    next_cycle();

    // vector table: RAW, WAW, x0, plain pipeline writes
    do_reset();
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,5,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        1,5, 0,0,0,        1,0,0,5, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 1,5,64'hAB,   1,5,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,5,0,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,5,0,0, 0,0,1,1,5,64'hAB));
    vecs.push_back(mk(0,0,0,        1,7, 0,0,0,        1,0,0,7, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,0,0,7, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        1,0, 0,0,0,        1,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,0,7,0, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        0,7,7,7, 0,0,1,0,0,0));
    vecs.push_back(mk(1,12,64'h1234,0,0, 0,0,0,        0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(1,0,64'h55,   0,0, 0,0,0,        0,0,0,0, 0,0,1,1,12,64'h1234));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 1,7,64'h77,   0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,0,0,7, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        1,0,0,7, 0,0,1,1,7,64'h77));
    vecs.push_back(mk(0,0,0,        0,0, 1,0,64'h99,   0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        0,0,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(1,7,64'hC7,   0,0, 0,0,0,        1,7,0,0, 0,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,        0,0, 0,0,0,        0,0,0,0, 0,0,1,1,7,64'hC7));
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // reset in the middle of a pending completion
    idle_inputs(); L_ISSUE = 1'b1; L_ISSUE_RD = 5'd6;
    next_cycle();
    idle_inputs(); L_DONE_VALID = 1'b1; L_DONE_RD = 5'd6; L_DONE_DATA = 64'h66;
    ID_VALID = 1'b1; ID_RS1 = 5'd6;
    @(negedge CLK);
    chk1("midrst_pre_stall", STALL, 1'b1);
    next_cycle();
    idle_inputs(); ID_VALID = 1'b1; ID_RS1 = 5'd6;
    RSTn = 1'b0;
    @(negedge CLK);
    chk1("midrst_stall", STALL, 1'b0);
    chk1("midrst_ready", L_DONE_READY, 1'b1);
    next_cycle();
    RSTn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk1("midrst_we", RF_WE, 1'b0);
      chk1("midrst_stall_after", STALL, 1'b0);
      next_cycle();
    end

    // starvation: buffer holds rd=3 while the pipeline writes every cycle
    do_reset();
    prd_s = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd16, 5'd0};
    for (int k = 0; k < 9; k++) begin
      idle_inputs();
      if (k < 8) begin
        P_VALID = 1'b1; P_RD = prd_s[k]; P_DATA = 64'h100 + 64'(prd_s[k]);
      end
      if (k == 0) begin L_ISSUE = 1'b1; L_ISSUE_RD = 5'd3; end
      if (k == 1) begin L_DONE_VALID = 1'b1; L_DONE_RD = 5'd3; L_DONE_DATA = 64'h33; end
      @(negedge CLK);
      chk1($sformatf("starve_hold_c%0d", k), HOLD, (k == 6));
      if (k == 0) begin
        chk1("starve_we_c0", RF_WE, 1'b0);
      end else if (k == 7) begin
        chk1("starve_we_c7", RF_WE, 1'b1);
        chk5("starve_wa_c7", RF_WA, 5'd3);
        chk64("starve_wd_c7", RF_WD, 64'h33);
      end else begin
        chk1($sformatf("starve_we_c%0d", k), RF_WE, 1'b1);
        chk5($sformatf("starve_wa_c%0d", k), RF_WA, prd_s[k-1]);
        chk64($sformatf("starve_wd_c%0d", k), RF_WD, 64'h100 + 64'(prd_s[k-1]));
      end
      next_cycle();
    end

    // backpressure: three completions back-to-back while the pipeline writes
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_inputs(); L_ISSUE = 1'b1; L_ISSUE_RD = 5'(20 + k);
      next_cycle();
    end
    prd_s  = '{5'd1, 5'd2, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    bp_we  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_wa  = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd20, 5'd21, 5'd22, 5'd0};
    bp_wd  = '{64'h0, 64'h201, 64'h202, 64'h204, 64'h205, 64'hA0, 64'hA1, 64'hA2, 64'h0};
    bp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 9; k++) begin
      idle_inputs();
      if (k < 4) begin
        P_VALID = 1'b1; P_RD = prd_s[k]; P_DATA = 64'h200 + 64'(prd_s[k]);
      end
      if (k == 0) begin L_DONE_VALID = 1'b1; L_DONE_RD = 5'd20; L_DONE_DATA = 64'hA0; end
      if (k == 1) begin L_DONE_VALID = 1'b1; L_DONE_RD = 5'd21; L_DONE_DATA = 64'hA1; end
      if (k >= 2 && k <= 5) begin L_DONE_VALID = 1'b1; L_DONE_RD = 5'd22; L_DONE_DATA = 64'hA2; end
      ID_VALID = 1'b1; ID_RS1 = 5'd22;
      @(negedge CLK);
      chk1($sformatf("bp_ready_c%0d", k), L_DONE_READY, bp_rdy[k]);
      chk1($sformatf("bp_hold_c%0d", k), HOLD, 1'b0);
      chk1($sformatf("bp_stall_c%0d", k), STALL, (k <= 6));
      chk1($sformatf("bp_we_c%0d", k), RF_WE, bp_we[k]);
      if (bp_we[k]) begin
        chk5($sformatf("bp_wa_c%0d", k), RF_WA, bp_wa[k]);
        chk64($sformatf("bp_wd_c%0d", k), RF_WD, bp_wd[k]);
      end
      next_cycle();
    end

    // same-register issue and retire in one cycle: the new issue keeps rd=9 busy
    do_reset();
    idle_inputs(); L_ISSUE = 1'b1; L_ISSUE_RD = 5'd9;
    next_cycle();
    idle_inputs(); L_DONE_VALID = 1'b1; L_DONE_RD = 5'd9; L_DONE_DATA = 64'h9;
    next_cycle();
    idle_inputs(); L_ISSUE = 1'b1; L_ISSUE_RD = 5'd9;
    next_cycle();
    idle_inputs(); ID_VALID = 1'b1; ID_RS1 = 5'd9;
    L_DONE_VALID = 1'b1; L_DONE_RD = 5'd9; L_DONE_DATA = 64'h19;
    @(negedge CLK);
    chk1("setclr_stall", STALL, 1'b1);
    chk1("setclr_we", RF_WE, 1'b1);
    chk5("setclr_wa", RF_WA, 5'd9);
    chk64("setclr_wd", RF_WD, 64'h9);
    next_cycle();
    idle_inputs(); ID_VALID = 1'b1; ID_RS1 = 5'd9;
    @(negedge CLK);
    chk1("setclr_stall2", STALL, 1'b1);
    next_cycle();
    idle_inputs(); ID_VALID = 1'b1; ID_RS1 = 5'd9;
    @(negedge CLK);
    chk1("setclr_stall3", STALL, 1'b0);
    chk1("setclr_we3", RF_WE, 1'b1);
    chk64("setclr_wd3", RF_WD, 64'h19);
    next_cycle();

    // randomized traffic against the reference model
    do_reset();
    for (int r = 0; r < 32; r++) mbusy[r] = 1'b0;
    mfifo.delete(); exp_q.delete(); unit_q.delete();
    mstarve = 0;
    begin
      bit last_hold = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit m_preq, m_lreq, m_grant_l, m_hold, m_ready, m_stall, accepted;
        logic [4:0] r;
        logic [68:0] w;
        if (!last_hold) begin
          P_VALID = 1'b0;
          if ($urandom_range(0, 99) < 60) begin
            r = 5'($urandom_range(0, 7));
            if (r == 5'd0 || !mbusy[r]) begin
              P_VALID = 1'b1; P_RD = r; P_DATA = {$urandom, $urandom};
            end
          end
        end
        if (!L_DONE_VALID && unit_q.size() > 0 && $urandom_range(0, 99) < 50) begin
          L_DONE_VALID = 1'b1; L_DONE_RD = unit_q[0]; L_DONE_DATA = {$urandom, $urandom};
        end
        ID_VALID = ($urandom_range(0, 99) < 70);
        ID_RS1 = 5'($urandom_range(0, 7));
        ID_RS2 = 5'($urandom_range(0, 7));
        ID_RD  = 5'($urandom_range(0, 7));
        m_stall = ID_VALID && (mbusy[ID_RS1] || mbusy[ID_RS2] || mbusy[ID_RD]);
        L_ISSUE = ID_VALID && !m_stall && ($urandom_range(0, 99) < 40) &&
                  !(P_VALID && ID_RD == P_RD);
        L_ISSUE_RD = ID_RD;

        m_preq    = P_VALID && (P_RD != 5'd0);
        m_lreq    = (mfifo.size() > 0);
        m_grant_l = m_lreq && (!m_preq || mstarve == STARVE_MAX);
        m_hold    = m_grant_l && m_preq;
        m_ready   = (mfifo.size() < LQ_DEPTH);

        @(negedge CLK);
        chk1("rnd_p_not_busy", m_preq && mbusy[P_RD], 1'b0);
        chk1("rnd_stall", STALL, m_stall);
        chk1("rnd_hold", HOLD, m_hold);
        chk1("rnd_ready", L_DONE_READY, m_ready);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk1("rnd_we", RF_WE, 1'b1);
          chk5("rnd_wa", RF_WA, w[68:64]);
          chk64("rnd_wd", RF_WD, w[63:0]);
        end else begin
          chk1("rnd_we_idle", RF_WE, 1'b0);
        end

        if (m_grant_l) begin
          w = mfifo.pop_front();
          mbusy[w[68:64]] = 1'b0;
          exp_q.push_back(w);
          mstarve = 0;
        end else if (m_preq) begin
          exp_q.push_back({P_RD, P_DATA});
          mstarve = m_lreq ? mstarve + 1 : 0;
        end else begin
          mstarve = 0;
        end
        if (L_ISSUE) begin
          if (L_ISSUE_RD != 5'd0) mbusy[L_ISSUE_RD] = 1'b1;
          unit_q.push_back(L_ISSUE_RD);
        end
        accepted = L_DONE_VALID && m_ready;
        if (accepted && L_DONE_RD != 5'd0) mfifo.push_back({L_DONE_RD, L_DONE_DATA});
        last_hold = m_hold;

        next_cycle();
        if (accepted) begin
          void'(unit_q.pop_front());
          L_DONE_VALID = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
